mem_arbiter_2p: RTL and testbench

Two-port arbiter sharing one single-ported memory bus between the instruction-fetch (IF) and memory (MEM) stages of `pipeline_5st`. It serialises requests onto the bus with at most one transaction outstanding. It prefers MEM, the older instruction, but bounds IF starvation with a streak counter. A flush input suppresses the response of an in-flight IF fetch without corrupting the bus handshake.

---
 rtl/ch0re_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 55 +++++
 rtl/mem_arbiter_2p.sv | 134 +++++++++++++
 tb/tb_mem_arbiter_2p.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch0re_arb_pkg.sv
// Shared types and defaults for the two-port IF/MEM memory bus arbiter.
package ch0re_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

    // Consecutive MEM grants over a waiting IF before IF is forced through.
    localparam int DEFAULT_MAX_MEM_STREAK = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the IF/MEM arbiter. MEM wins ties until it has won
// MAX_MEM_STREAK times in a row over a waiting IF, then IF is forced.
module mem_arb_pick
    import ch0re_arb_pkg::*;
#(
    parameter int MAX_MEM_STREAK = DEFAULT_MAX_MEM_STREAK
) (
    input  logic clk,
    input  logic rst_,
    input  logic idle,
    input  logic if_valid,
    input  logic mem_valid,
    input  logic flush,
    output logic grant_if,
    output logic grant_mem
);

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

    logic [SW-1:0] streak;
    logic          if_eligible;

    // Pick at most one winner, and only while the arbiter is idle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant_if    = 1'b0;
        grant_mem   = 1'b0;
        if_eligible = if_valid && !flush;
        if (idle) begin
            if (if_eligible && (!mem_valid || streak == STREAK_MAX)) begin
                grant_if = 1'b1;
            end else if (mem_valid) begin
                grant_mem = 1'b1;
            end
        end
    end

    // Count MEM wins over a waiting IF; any IF win or an uncontested MEW win resets it.
    always_ff @(posedge clk or negedge rst_) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_mem) begin
            if (!if_valid) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Shares one single-ported memory bus between the IF and MEM pipeline stages.
// One transaction outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// A flush kills the response of an in-flight IF fetch while the bus
// transaction itself always runs to completion.
module mem_arbiter_2p
    import ch0re_arb_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MAX_MEM_STREAK = DEFAULT_MAX_MEM_STREAK
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                mem_req_valid,
    input  logic                mem_req_we,
    input  logic [ADDR_W-1:0]   mem_req_addr,
    input  logic [DATA_W-1:0]   mem_req_wdata,
    input  logic [DATA_W/8-1:0] mem_req_be,
    output logic                mem_req_ready,
    output logic                mem_rsp_valid,
    output logic [DATA_W-1:0]   mem_rsp_rdata,
    input  logic                flush,
    output logic                bus_req_valid,
    output logic                bus_req_we,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [DATA_W-1:0]   bus_req_wdata,
    output logic [DATA_W/8-1:0] bus_req_be,
    input  logic                bus_req_ready,
    input  logic                bus_rsp_valid,
    input  logic [DATA_W-1:0]   bus_rsp_rdata
);

    arb_state_e        state;
    arb_owner_e        owner;
    logic              kill;
    logic [DATA_W-1:0] rsp_data;
    logic              grant_if;
    logic              grant_mem;
    logic              idle;

    // No grants while reset is held, so the ready outputs also read 0 then.
    assign idle = (state == IDLE) && rst_;

    mem_arb_pick #(
        .MAX_MEM_STREAK(MAX_MEM_STREAK)
    ) u_pick (
        .clk      (clk),
        .rst_     (rst_),
        .idle     (idle),
        .if_valid (if_req_valid),
        .mem_valid(mem_req_valid),
        .flush    (flush),
        .grant_if (grant_if),
        .grant_mem(grant_mem)
    );

    assign if_req_ready  = grant_if;
    assign mem_req_ready = grant_mem;
    assign if_rsp_valid  = (state == RESP) && (owner == OWN_IF) && !kill;
    assign mem_rsp_valid = (state == RESP) && (owner == OWN_MEM);
    assign if_rsp_data   = rsp_data;
    assign mem_rsp_rdata = rsp_data;

    // Transaction FSM: latch the winner's request, drive the bus, capture the response.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            bus_req_be    <= '0;
            rsp_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state         <= ISSUE;
                        owner         <= OWN_MEM;
                        bus_req_valid <= 1'b1;
                        bus_req_we    <= mem_req_we;
                        bus_req_addr  <= mem_req_addr;
                        bus_req_wdata <= mem_req_wdata;
                        bus_req_be    <= mem_req_be;
                    end else if (grant_if) begin
                        state         <= ISSUE;
                        owner         <= OWN_IF;
                        bus_req_valid <= 1'b1;
                        bus_req_we    <= 1'b0;
                        bus_req_addr  <= if_req_addr;
                        bus_req_wdata <= '0;
                        bus_req_be    <= '1;
                    end
                end
                ISSUE: begin
                    if (bus_req_ready) begin
                        state         <= WAIT;
                        bus_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        state    <= RESP;
                        rsp_data <= bus_rsp_rdata;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky kill for an IF transaction flushed after its grant; cleared on the way back to IDLE.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            kill <= 1'b0;
        end else if (state == RESP) begin
            kill <= 1'b0;
        end else if (flush && owner == OWN_IF && state != IDLE) begin
            kill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p: a table of idle-state arbitration
// vectors, then hand-written multi-cycle sequences against a simple bus responder.
module tb_mem_arbiter_2p;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [BE_W-1:0]   mem_req_be;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
    logic              flush;
    logic              bus_req_valid;
    logic              bus_req_we;
    logic [ADDR_W-1:0] bus_req_addr;
    logic [DATA_W-1:0] bus_req_wdata;
    logic [BE_W-1:0]   bus_req_be;
    logic              bus_req_ready;
    logic              bus_rsp_valid;
    logic [DATA_W-1:0] bus_rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_2p #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_MEM_STREAK(4)
    ) dut (
        .clk          (clk),
        .rst_         (rst_),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_we   (mem_req_we),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_be   (mem_req_be),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .flush        (flush),
        .bus_req_valid(bus_req_valid),
        .bus_req_we   (bus_req_we),
        .bus_req_addr (bus_req_addr),
        .bus_req_wdata(bus_req_wdata),
        .bus_req_be   (bus_req_be),
        .bus_req_ready(bus_req_ready),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata)
    );

    // Memory contents as seen by the responder.
    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h100) return 64'hDEAD_BEEF;
        return a ^ 64'h5A5A_5A5A_0000_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus responder: answers one cycle after each accepted request.
    logic              rsp_enable = 1'b1;
    logic              force_rsp  = 1'b0;
    logic              resp_hs;
    logic [ADDR_W-1:0] resp_addr;
    initial begin
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            resp_hs   = bus_req_valid && bus_req_ready;
            resp_addr = bus_req_addr;
            @(posedge clk);
            #2;
            bus_rsp_valid = (resp_hs && rsp_enable) || force_rsp;
            bus_rsp_rdata = resp_hs ? mem_model(resp_addr) : 64'h0;
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic if_v;
        logic mem_v;
        logic fl;
        logic exp_if_rdy;
        logic exp_mem_rdy;
    } arb_vec_t;

    arb_vec_t vecs[8];

    int       if_gcyc, mem_gcyc, if_rcyc, mem_rcyc;
    logic [63:0] if_rdat, mem_rdat;
    logic     drop_if, drop_mem;
    logic     gseq[6];
    int       ng;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_          = 1'b0;
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_be    = '0;
        flush         = 1'b0;
        bus_req_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_bus_valid", bus_req_valid, 0);
        check("rst_bus_addr", bus_req_addr, 0);
        check("rst_if_rsp", if_rsp_valid, 0);
        check("rst_mem_rsp", mem_rsp_valid, 0);
        tick();
        rst_ = 1'b1;
        tick();

        // Idle arbitration table (streak is 0; inputs dropped before the edge).
        for (int i = 0; i < 8; i++) begin
            if_req_valid  = vecs[i].if_v;
            if_req_addr   = 64'h40;
            mem_req_valid = vecs[i].mem_v;
            mem_req_addr  = 64'h80;
            flush         = vecs[i].fl;
            @(negedge clk);
            check($sformatf("vec%0d_if_ready", i), if_req_ready, vecs[i].exp_if_rdy);
            check($sformatf("vec%0d_mem_ready", i), mem_req_ready, vecs[i].exp_mem_rdy);
            if_req_valid  = 1'b0;
            mem_req_valid = 1'b0;
            flush         = 1'b0;
            tick();
        end

        // Lone IF fetch, no stalls.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h100;
        @(negedge clk);
        check("t1_if_ready", if_req_ready, 1);
        check("t1_mem_ready", mem_req_ready, 0);
        tick();
        if_req_valid = 1'b0;
        @(negedge clk);
        check("t1_bus_valid", bus_req_valid, 1);
        check("t1_bus_addr", bus_req_addr, 64'h100);
        check("t1_bus_we", bus_req_we, 0);
        tick();
        @(negedge clk);
        check("t1_rsp_early", if_rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t1_if_rsp", if_rsp_valid, 1);
        check("t1_if_data", if_rsp_data, 64'hDEAD_BEEF);
        check("t1_mem_rsp", mem_rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t1_rsp_pulse", if_rsp_valid, 0);
        tick();

        // IF and MEM load together: MEM first, responses in grant order.
        if_req_valid  = 1'b1;
        if_req_addr   = 64'h300;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b0;
        mem_req_addr  = 64'h400;
        if_gcyc = -1; mem_gcyc = -1; if_rcyc = -1; mem_rcyc = -1;
        if_rdat = '0; mem_rdat = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            drop_if  = if_req_ready;
            drop_mem = mem_req_ready;
            if (if_req_ready)  if_gcyc = c;
            if (mem_req_ready) mem_gcyc = c;
            if (if_rsp_valid)  begin if_rcyc = c;  if_rdat = if_rsp_data;    end
            if (mem_rsp_valid) begin mem_rcyc = c; mem_rdat = mem_rsp_rdata; end
            tick();
            if (drop_if)  if_req_valid = 1'b0;
            if (drop_mem) mem_req_valid = 1'b0;
        end
        check("t2_mem_grant_cyc", 64'(mem_gcyc), 0);
        check("t2_if_grant_cyc", 64'(if_gcyc), 4);
        check("t2_mem_rsp_cyc", 64'(mem_rcyc), 3);
        check("t2_mem_rsp_data", mem_rdat, mem_model(64'h400));
        check("t2_if_rsp_cyc", 64'(if_rcyc), 7);
        check("t2_if_rsp_data", if_rdat, mem_model(64'h300));

        // Both held valid: MEM x4, IF, MEM.
        if_req_valid  = 1'b1;
        if_req_addr   = 64'h1000;
        mem_req_valid = 1'b1;
        mem_req_addr  = 64'h2000;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (mem_req_ready) begin
                gseq[ng] = 1'b1;
                ng++;
            end else if (if_req_ready) begin
                gseq[ng] = 1'b0;
                ng++;
            end
            tick();
        end
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b0;
        check("t3_grant_count", 64'(ng), 6);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("t3_grant%0d_is_mem", k), 64'(gseq[k]), (k == 4) ? 64'd0 : 64'd1);
        end
        repeat (6) tick();

        // MEM store with 3 cycles of bus stall.
        bus_req_ready = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = 64'h200;
        mem_req_wdata = 64'h1122_3344_5566_7788;
        mem_req_be    = 8'h0F;
        @(negedge clk);
        check("t4_mem_ready", mem_req_ready, 1);
        tick();
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_wdata = '0;
        mem_req_be    = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) bus_req_ready = 1'b1;
            @(negedge clk);
            check($sformatf("t4_valid_T%0d", k), bus_req_valid, 1);
            check($sformatf("t4_addr_T%0d", k), bus_req_addr, 64'h200);
            check($sformatf("t4_we_T%0d", k), bus_req_we, 1);
            check($sformatf("t4_be_T%0d", k), 64'(bus_req_be), 64'h0F);
            check($sformatf("t4_wdata_T%0d", k), bus_req_wdata, 64'h1122_3344_5566_7788);
            check($sformatf("t4_rsp_T%0d", k), mem_rsp_valid, 0);
            tick();
        end
        @(negedge clk);
        check("t4_rsp_T5", mem_rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t4_rsp_T6", mem_rsp_valid, 1);
        check("t4_if_rsp_T6", if_rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t4_rsp_T7", mem_rsp_valid, 0);
        tick();

        // Flush during WAIT of an IF fetch.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h700;
        @(negedge clk);
        check("t5_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t5_killed_rsp", if_rsp_valid, 0);
        tick();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h500;
        @(negedge clk);
        check("t5_no_late_rsp", if_rsp_valid, 0);
        check("t5_next_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t5_next_if_rsp", if_rsp_valid, 1);
        check("t5_next_if_data", if_rsp_data, mem_model(64'h500));
        tick();

        // Reset while waiting on the bus.
        rsp_enable   = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h600;
        @(negedge clk);
        check("t6_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t6_wait_bus_valid", bus_req_valid, 0);
        check("t6_wait_no_rsp", if_rsp_valid, 0);
        rst_ = 1'b0;
        #1;
        check("t6_rst_bus_addr", bus_req_addr, 0);
        check("t6_rst_bus_be", 64'(bus_req_be), 0);
        check("t6_rst_if_data", if_rsp_data, 0);
        check("t6_rst_mem_data", mem_rsp_rdata, 0);
        check("t6_rst_if_rsp", if_rsp_valid, 0);
        tick();
        rst_ = 1'b1;
        tick();
        rsp_enable = 1'b1;
        force_rsp  = 1'b1;
        @(negedge clk);
        check("t6_stray_rsp0", if_rsp_valid, 0);
        tick();
        force_rsp = 1'b0;
        @(negedge clk);
        check("t6_stray_rsp1_if", if_rsp_valid, 0);
        check("t6_stray_rsp1_mem", mem_rsp_valid, 0);
        tick();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h800;
        @(negedge clk);
        check("t6_stray_rsp2", if_rsp_valid, 0);
        check("t6_post_rst_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t6_post_rst_rsp", if_rsp_valid, 1);
        check("t6_post_rst_data", if_rsp_data, mem_model(64'h800));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
